// File: rtl/fu_branch_resolver_if.sv
// fu_branch_resolver_if: fetch prediction, execute resolve and BTB update signals.
interface fu_branch_resolver_if #(parameter int WORD_W = 32);
  logic              ihit;
  logic              pred_push;
  logic [WORD_W-1:0] pred_pc;
  logic              pred_outcome;
  logic [WORD_W-1:0] pred_target;
  logic              pred_full;
  logic              resolve_valid;
  logic [WORD_W-1:0] resolve_pc;
  logic              resolve_taken;
  logic [WORD_W-1:0] resolve_target;
  logic              resolve_ready;
  logic              update_btb;
  logic [WORD_W-1:0] update_pc;
  logic              branch_outcome;
  logic [WORD_W-1:0] branch_target;
  logic              flush;
  logic [WORD_W-1:0] redirect_pc;
  logic              order_error;
  modport master (
    output ihit, pred_push, pred_pc, pred_outcome, pred_target,
           resolve_valid, resolve_pc, resolve_taken, resolve_target,
    input  pred_full, resolve_ready, update_btb, update_pc, branch_outcome,
           branch_target, flush, redirect_pc, order_error
  );
  modport slave (
    input  ihit, pred_push, pred_pc, pred_outcome, pred_target,
           resolve_valid, resolve_pc, resolve_taken, resolve_target,
    output pred_full, resolve_ready, update_btb, update_pc, branch_outcome,
           branch_target, flush, redirect_pc, order_error
  );
endinterface

// File: rtl/fu_branch_resolver.sv
// fu_branch_resolver: in-order prediction queue checked at resolve; drives BTB update and flush.
// Optional BRANCH_STATS_EN adds resolve/mispredict counters.
module fu_branch_resolver #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  fu_branch_resolver_if.slave bif
`ifdef BRANCH_STATS_EN
  ,
  output logic [WORD_W-1:0] stat_resolved,
  output logic [WORD_W-1:0] stat_mispredict
`endif
);
  logic [WORD_W-1:0] pc_q [DEPTH];
  logic [WORD_W-1:0] tgt_q [DEPTH];
  logic [DEPTH-1:0]  out_q;
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              upd_q, bout_q, flush_q, oerr_q;
  logic [WORD_W-1:0] upc_q, btgt_q, red_q;
  logic              push, acc, pc_err, mis;
  assign bif.pred_full      = cnt_q == (PTR_W+1)'(DEPTH);
  assign bif.resolve_ready  = cnt_q != '0 && (!upd_q || bif.ihit);
  assign bif.update_btb     = upd_q;
  assign bif.update_pc      = upc_q;
  assign bif.branch_outcome = bout_q;
  assign bif.branch_target  = btgt_q;
  assign bif.flush          = flush_q;
  assign bif.redirect_pc    = red_q;
  assign bif.order_error    = oerr_q;
  assign push   = bif.pred_push && !bif.pred_full;
  assign acc    = bif.resolve_valid && bif.resolve_ready;
  assign pc_err = pc_q[rd_q] != bif.resolve_pc;
  assign mis    = acc && (out_q[rd_q] != bif.resolve_taken ||
                  (bif.resolve_taken && tgt_q[rd_q] != bif.resolve_target) || pc_err);
  // A mispredict empties the queue, discarding younger entries and any same-cycle push.
  always_comb begin
    rd_d  = mis ? '0 : rd_q + PTR_W'(acc);
    wr_d  = mis ? '0 : wr_q + PTR_W'(push);
    cnt_d = mis ? '0 : cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(acc);
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      upd_q   <= 1'b0;
      upc_q   <= '0;
      bout_q  <= 1'b0;
      btgt_q  <= '0;
      flush_q <= 1'b0;
      red_q   <= '0;
      oerr_q  <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      flush_q <= mis;
      oerr_q  <= acc && pc_err;
      if (mis) red_q <= bif.resolve_taken ? bif.resolve_target : bif.resolve_pc + WORD_W'(4);
      if (acc) begin
        upd_q  <= 1'b1;
        upc_q  <= bif.resolve_pc;
        bout_q <= bif.resolve_taken;
        btgt_q <= bif.resolve_target;
      end else if (bif.ihit) begin
        upd_q  <= 1'b0;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (push && !mis) begin
      pc_q[wr_q]  <= bif.pred_pc;
      tgt_q[wr_q] <= bif.pred_target;
      out_q[wr_q] <= bif.pred_outcome;
    end
  end
`ifdef BRANCH_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_resolved   <= '0;
      stat_mispredict <= '0;
    end else begin
      stat_resolved   <= stat_resolved + WORD_W'(acc);
      stat_mispredict <= stat_mispredict + WORD_W'(mis);
    end
  end
`endif
endmodule

// File: tb/tb_fu_branch_resolver.sv
// tb_fu_branch_resolver: directed test plan then random traffic against a queue-based model.
module tb_fu_branch_resolver;
  localparam int DEPTH = 4;
  logic CLK, nRST;
  int checks = 0, errors = 0;
  fu_branch_resolver_if #(.WORD_W(32)) bif ();
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_r, stat_m;
`endif
  fu_branch_resolver #(.WORD_W(32), .DEPTH(DEPTH), .PTR_W(2)) dut (
    .CLK(CLK), .nRST(nRST), .bif(bif)
`ifdef BRANCH_STATS_EN
    , .stat_resolved(stat_r), .stat_mispredict(stat_m)
`endif
  );
  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end
  typedef struct {logic [31:0] pc; bit o; logic [31:0] t;} ent_t;
  ent_t q[$];
  bit m_upd, m_out, m_flush, m_oerr;
  logic [31:0] m_upc, m_tgt, m_red;
  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endfunction
  task automatic model_reset();
    q.delete();
    {m_upd, m_out, m_flush, m_oerr} = '0;
    {m_upc, m_tgt, m_red} = '0;
  endtask
  task automatic drive(bit ph, logic [31:0] ppc, bit po, logic [31:0] pt,
                       bit rv, logic [31:0] rpc, bit rt, logic [31:0] rtg, bit ih);
    bif.pred_push = ph; bif.pred_pc = ppc; bif.pred_outcome = po; bif.pred_target = pt;
    bif.resolve_valid = rv; bif.resolve_pc = rpc; bif.resolve_taken = rt;
    bif.resolve_target = rtg; bif.ihit = ih;
  endtask
  task automatic push(logic [31:0] pc, bit o, logic [31:0] t);
    drive(1, pc, o, t, 0, 0, 0, 0, 1);
  endtask
  task automatic resolve(logic [31:0] pc, bit tk, logic [31:0] t, bit ih);
    drive(0, 0, 0, 0, 1, pc, tk, t, ih);
  endtask
  task automatic idle(bit ih);
    drive(0, 0, 0, 0, 0, 0, 0, 0, ih);
  endtask
  task automatic check_outs();
    chk("update_btb", bif.update_btb, m_upd);
    chk("update_pc", bif.update_pc, m_upc);
    chk("branch_outcome", bif.branch_outcome, m_out);
    chk("branch_target", bif.branch_target, m_tgt);
    chk("flush", bif.flush, m_flush);
    chk("redirect_pc", bif.redirect_pc, m_red);
    chk("order_error", bif.order_error, m_oerr);
  endtask
  // One clock: check combinational outputs, predict the edge, then check registered outputs.
  task automatic step();
    ent_t h, n;
    bit rdy, acc, mis, pe, pok, rt;
    logic [31:0] rpc, rtg;
    #1;
    rdy = q.size() != 0 && (!m_upd || bif.ihit);
    chk("pred_full", bif.pred_full, 32'(q.size() == DEPTH));
    chk("resolve_ready", bif.resolve_ready, 32'(rdy));
    pok = bif.pred_push && q.size() < DEPTH;
    n = '{bif.pred_pc, bif.pred_outcome, bif.pred_target};
    acc = bif.resolve_valid && rdy;
    rpc = bif.resolve_pc; rt = bif.resolve_taken; rtg = bif.resolve_target;
    pe = 0; mis = 0;
    if (acc) begin
      h = q[0];
      pe = h.pc != rpc;
      mis = pe || h.o != rt || (rt && h.t != rtg);
    end
    @(posedge CLK);
    #1;
    m_flush = mis;
    m_oerr = acc && pe;
    if (mis) m_red = rt ? rtg : rpc + 32'd4;
    if (acc) begin
      m_upd = 1; m_upc = rpc; m_out = rt; m_tgt = rtg;
    end else if (bif.ihit) m_upd = 0;
    if (mis) q.delete();
    else begin
      if (acc) void'(q.pop_front());
      if (pok) q.push_back(n);
    end
    check_outs();
  endtask
  initial begin
    nRST = 0;
    idle(0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_outs();
    chk("reset_pred_full", bif.pred_full, 0);
    chk("reset_resolve_ready", bif.resolve_ready, 0);
    nRST = 1;
    // correct taken prediction
    push(32'h100, 1, 32'h80); step();
    resolve(32'h100, 1, 32'h80, 1); step();
    chk("t1_update_btb", bif.update_btb, 1);
    chk("t1_update_pc", bif.update_pc, 32'h100);
    chk("t1_branch_target", bif.branch_target, 32'h80);
    chk("t1_flush", bif.flush, 0);
    idle(1); step();
    chk("t1_update_drop", bif.update_btb, 0);
    // wrong direction
    push(32'h200, 0, 32'h204); step();
    resolve(32'h200, 1, 32'h40, 1); step();
    chk("t2_flush", bif.flush, 1);
    chk("t2_redirect", bif.redirect_pc, 32'h40);
    chk("t2_ready", bif.resolve_ready, 0);
    idle(1); step();
    chk("t2_flush_pulse", bif.flush, 0);
    chk("t2_redirect_hold", bif.redirect_pc, 32'h40);
    // wrong target, then not-taken redirect
    push(32'h300, 1, 32'h10); step();
    resolve(32'h300, 1, 32'h20, 1); step();
    chk("t3_redirect", bif.redirect_pc, 32'h20);
    push(32'h400, 1, 32'h10); step();
    resolve(32'h400, 0, 32'h0, 1); step();
    chk("t3_redirect_nt", bif.redirect_pc, 32'h404);
    chk("t3_branch_outcome", bif.branch_outcome, 0);
    // full and wrap
    for (int i = 1; i <= 5; i++) begin
      push(32'h1000 + 32'(i * 16), 1, 32'h2000 + 32'(i)); step();
    end
    chk("t4_full", bif.pred_full, 1);
    for (int i = 1; i <= 4; i++) begin
      resolve(32'h1000 + 32'(i * 16), 1, 32'h2000 + 32'(i), 1); step();
      chk("t4_no_flush", bif.flush, 0);
    end
    for (int i = 6; i <= 7; i++) begin
      push(32'h1000 + 32'(i * 16), 0, 32'h0); step();
    end
    for (int i = 6; i <= 7; i++) begin
      resolve(32'h1000 + 32'(i * 16), 0, 32'h0, 1); step();
      chk("t4_wrap_pc", bif.update_pc, 32'h1000 + 32'(i * 16));
      chk("t4_wrap_flush", bif.flush, 0);
    end
    // update stall while ihit is low
    push(32'h600, 1, 32'h60); step();
    push(32'h610, 1, 32'h70); step();
    resolve(32'h600, 1, 32'h60, 0); step();
    for (int i = 0; i < 3; i++) begin
      resolve(32'h610, 1, 32'h70, 0); step();
      chk("t5_held", bif.update_btb, 1);
      chk("t5_pc_stable", bif.update_pc, 32'h600);
      chk("t5_ready", bif.resolve_ready, 0);
    end
    idle(1); step();
    chk("t5_drop", bif.update_btb, 0);
    resolve(32'h610, 1, 32'h70, 1); step();
    // order error, then async reset with a pending update
    push(32'h500, 1, 32'h50); step();
    resolve(32'h504, 1, 32'h50, 1); step();
    chk("t6_order_error", bif.order_error, 1);
    chk("t6_flush", bif.flush, 1);
    chk("t6_redirect", bif.redirect_pc, 32'h50);
    push(32'h700, 0, 32'h0); step();
    push(32'h710, 0, 32'h0); step();
    resolve(32'h700, 0, 32'h0, 0); step();
    chk("t6_pending", bif.update_btb, 1);
    #2 nRST = 0;
    #1;
    model_reset();
    check_outs();
    chk("t6_rst_full", bif.pred_full, 0);
    chk("t6_rst_ready", bif.resolve_ready, 0);
    @(posedge CLK);
    #1 nRST = 1;
    idle(1);
    // random traffic
    for (int k = 0; k < 600; k++) begin
      bit ph, rv, rt, ih;
      logic [31:0] rpc, rtg;
      ph = $urandom_range(0, 2) != 0;
      ih = $urandom_range(0, 3) != 0;
      rv = $urandom_range(0, 2) != 0;
      rpc = 32'h100 + 32'($urandom_range(0, 7) * 4);
      rt = 1'($urandom_range(0, 1));
      rtg = 32'h40 * 32'($urandom_range(1, 2));
      if (q.size() != 0 && $urandom_range(0, 7) != 0) begin
        rpc = q[0].pc;
        if ($urandom_range(0, 5) != 0) begin rt = q[0].o; rtg = q[0].t; end
      end
      drive(ph, 32'h100 + 32'($urandom_range(0, 7) * 4), 1'($urandom_range(0, 1)),
            32'h40 * 32'($urandom_range(1, 2)), rv, rpc, rt, rtg, ih);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
